// File: rtl/wb_register_file.sv
// Writeback stage: selects the MEM/WB result, commits it to a 32x32 register file
// and serves two combinational read ports with same-cycle write-through bypass.
module wb_register_file (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        RegWrite_i,
  input  logic        MemtoReg_i,
  input  logic [31:0] dataMem_data_i,
  input  logic [31:0] ALU_result_i,
  input  logic [4:0]  RDaddr_i,
  input  logic [4:0]  RSaddr_i,
  input  logic [4:0]  RTaddr_i,
  output logic [31:0] RSdata_o,
  output logic [31:0] RTdata_o,
  output logic [31:0] WBdata_o,
  output logic [4:0]  WBaddr_o,
  output logic        WBvalid_o
);

  logic [31:0] r_regs [32];
  logic        w_we;
  logic [31:0] w_wbdata;

  assign w_wbdata  = MemtoReg_i ? dataMem_data_i : ALU_result_i;
  assign w_we      = RegWrite_i && (RDaddr_i != 5'd0);
  assign WBdata_o  = w_wbdata;
  assign WBvalid_o = w_we;
  assign WBaddr_o  = w_we ? RDaddr_i : 5'd0;

  // r_regs[0] is cleared by reset and never targeted, since w_we excludes address 0
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (w_we) begin
      r_regs[RDaddr_i] <= w_wbdata;
    end
  end

  always_comb begin
    RSdata_o = r_regs[RSaddr_i];
    if (RSaddr_i == 5'd0)
      RSdata_o = '0;
    else if (w_we && (RSaddr_i == RDaddr_i))
      RSdata_o = w_wbdata;
  end

  always_comb begin
    RTdata_o = r_regs[RTaddr_i];
    if (RTaddr_i == 5'd0)
      RTdata_o = '0;
    else if (w_we && (RTaddr_i == RDaddr_i))
      RTdata_o = w_wbdata;
  end

endmodule

// File: tb/tb_wb_register_file.sv
// Directed bench for wb_register_file: stimulus pushes expected values into a
// scoreboard queue and a monitor process compares them against the DUT outputs.
module tb_wb_register_file;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        RegWrite_i = 1'b0;
  logic        MemtoReg_i = 1'b0;
  logic [31:0] dataMem_data_i = '0;
  logic [31:0] ALU_result_i = '0;
  logic [4:0]  RDaddr_i = '0;
  logic [4:0]  RSaddr_i = '0;
  logic [4:0]  RTaddr_i = '0;
  logic [31:0] RSdata_o, RTdata_o, WBdata_o;
  logic [4:0]  WBaddr_o;
  logic        WBvalid_o;

  wb_register_file dut (
    .clk_i(clk_i), .rst_i(rst_i), .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i),
    .dataMem_data_i(dataMem_data_i), .ALU_result_i(ALU_result_i),
    .RDaddr_i(RDaddr_i), .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i),
    .RSdata_o(RSdata_o), .RTdata_o(RTdata_o), .WBdata_o(WBdata_o),
    .WBaddr_o(WBaddr_o), .WBvalid_o(WBvalid_o)
  );

  always #5 clk_i = ~clk_i;

  localparam int SEL_RS = 0, SEL_RT = 1, SEL_WBD = 2, SEL_WBA = 3, SEL_WBV = 4;

  typedef struct {
    string       nm;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sbq[$];
  event sample_ev;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic expect_val(input string nm, input int sel, input logic [31:0] exp);
    exp_t e;
    e.nm = nm; e.sel = sel; e.exp = exp;
    sbq.push_back(e);
  endtask

  // Let combinational outputs settle, then hand the queued expectations to the monitor
  task automatic sample();
    #1;
    -> sample_ev;
    #1;
  endtask

  initial begin : monitor
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(sample_ev);
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        case (e.sel)
          SEL_RS:  act = RSdata_o;
          SEL_RT:  act = RTdata_o;
          SEL_WBD: act = WBdata_o;
          SEL_WBA: act = {27'd0, WBaddr_o};
          default: act = {31'd0, WBvalid_o};
        endcase
        n_tests++;
        if (act !== e.exp) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", e.nm, act, e.exp);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    // Reset state
    RSaddr_i = 5'd5; RTaddr_i = 5'd31;
    @(negedge clk_i);
    expect_val("reset_rs5", SEL_RS, 32'h0);
    expect_val("reset_rt31", SEL_RT, 32'h0);
    sample();
    rst_i = 1'b0;

    // Load r5, then clear it with an unaligned asynchronous reset pulse
    @(negedge clk_i);
    RegWrite_i = 1'b1; MemtoReg_i = 1'b0; ALU_result_i = 32'hDEADBEEF; RDaddr_i = 5'd5;
    expect_val("r5_bypass", SEL_RS, 32'hDEADBEEF);
    sample();
    @(negedge clk_i);
    RegWrite_i = 1'b0;
    expect_val("r5_stored", SEL_RS, 32'hDEADBEEF);
    sample();
    #2 rst_i = 1'b1;
    expect_val("async_reset_rs5", SEL_RS, 32'h0);
    sample();
    rst_i = 1'b0;
    @(negedge clk_i);
    expect_val("after_reset_rs5", SEL_RS, 32'h0);
    sample();

    // Basic write from ALU, then from memory
    RegWrite_i = 1'b1; MemtoReg_i = 1'b0; ALU_result_i = 32'h12345678; RDaddr_i = 5'd7;
    dataMem_data_i = 32'hCAFEF00D;
    expect_val("wbdata_alu", SEL_WBD, 32'h12345678);
    expect_val("wbvalid_r7", SEL_WBV, 32'h1);
    expect_val("wbaddr_r7", SEL_WBA, 32'd7);
    sample();
    @(negedge clk_i);
    MemtoReg_i = 1'b1; RDaddr_i = 5'd8; RSaddr_i = 5'd7; RTaddr_i = 5'd8;
    expect_val("r7_stored", SEL_RS, 32'h12345678);
    expect_val("wbdata_mem", SEL_WBD, 32'hCAFEF00D);
    sample();
    @(negedge clk_i);
    RegWrite_i = 1'b0;
    expect_val("r8_stored", SEL_RT, 32'hCAFEF00D);
    expect_val("wbvalid_off", SEL_WBV, 32'h0);
    expect_val("wbaddr_off", SEL_WBA, 32'h0);
    expect_val("wbdata_mux_no_we", SEL_WBD, 32'hCAFEF00D);
    sample();

    // Bypass on both ports to the same address
    @(negedge clk_i);
    RegWrite_i = 1'b1; MemtoReg_i = 1'b0; ALU_result_i = 32'hA5A5A5A5; RDaddr_i = 5'd9;
    RSaddr_i = 5'd9; RTaddr_i = 5'd9;
    expect_val("bypass_rs9", SEL_RS, 32'hA5A5A5A5);
    expect_val("bypass_rt9", SEL_RT, 32'hA5A5A5A5);
    expect_val("bypass_wbvalid", SEL_WBV, 32'h1);
    expect_val("bypass_wbaddr", SEL_WBA, 32'd9);
    sample();
    @(negedge clk_i);
    RegWrite_i = 1'b0;
    expect_val("r9_stored", SEL_RS, 32'hA5A5A5A5);
    sample();

    // Ports resolve independently: one bypassed, one from the array
    RegWrite_i = 1'b1; ALU_result_i = 32'h00000055; RDaddr_i = 5'd7;
    RSaddr_i = 5'd8; RTaddr_i = 5'd7;
    expect_val("indep_rs8", SEL_RS, 32'hCAFEF00D);
    expect_val("indep_rt7_bypass", SEL_RT, 32'h00000055);
    sample();
    @(negedge clk_i);
    RegWrite_i = 1'b0;
    expect_val("r7_overwritten", SEL_RT, 32'h00000055);
    sample();

    // r0 protection
    RegWrite_i = 1'b1; ALU_result_i = 32'hFFFFFFFF; RDaddr_i = 5'd0;
    RSaddr_i = 5'd0; RTaddr_i = 5'd0;
    expect_val("r0_wbvalid", SEL_WBV, 32'h0);
    expect_val("r0_wbaddr", SEL_WBA, 32'h0);
    expect_val("r0_rs_pre", SEL_RS, 32'h0);
    expect_val("r0_rt_pre", SEL_RT, 32'h0);
    expect_val("r0_wbdata", SEL_WBD, 32'hFFFFFFFF);
    sample();
    @(negedge clk_i);
    RegWrite_i = 1'b0;
    expect_val("r0_rs_post", SEL_RS, 32'h0);
    sample();

    // Write disabled: no bypass, no commit
    RegWrite_i = 1'b0; ALU_result_i = 32'h00000001; RDaddr_i = 5'd7; RSaddr_i = 5'd7;
    expect_val("nowe_rs7_pre", SEL_RS, 32'h00000055);
    expect_val("nowe_wbvalid", SEL_WBV, 32'h0);
    sample();
    @(negedge clk_i);
    expect_val("nowe_rs7_post", SEL_RS, 32'h00000055);
    sample();

    // Back-to-back writes to r3
    RSaddr_i = 5'd3; RTaddr_i = 5'd3; RDaddr_i = 5'd3; RegWrite_i = 1'b1;
    for (int v = 1; v <= 3; v++) begin
      ALU_result_i = 32'(v);
      expect_val($sformatf("b2b_rs3_%0d", v), SEL_RS, 32'(v));
      sample();
      @(negedge clk_i);
    end
    RegWrite_i = 1'b0;
    expect_val("b2b_rs3_final", SEL_RS, 32'd3);
    expect_val("b2b_rt3_final", SEL_RT, 32'd3);
    sample();

    // Reset releasing while a write is presented: commit on the next edge
    rst_i = 1'b1;
    RegWrite_i = 1'b1; ALU_result_i = 32'h0BADCAFE; RDaddr_i = 5'd12; RSaddr_i = 5'd3;
    RTaddr_i = 5'd12;
    expect_val("rst_clears_r3", SEL_RS, 32'h0);
    sample();
    rst_i = 1'b0;
    @(negedge clk_i);
    RegWrite_i = 1'b0;
    expect_val("post_rst_commit_r12", SEL_RT, 32'h0BADCAFE);
    sample();

    #2;
    n_tests++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_register_file.md
# wb_register_file

Writeback-stage consumer of the MEM/WB pipeline register. It selects the writeback value (memory data or ALU result), commits it to a 32×32-bit general-purpose register file on the clock edge, and serves the ID stage through two combinational read ports with same-cycle write-through bypass. It also exports the selected writeback value and destination for the forwarding unit.

## Interface
- No parameters. Fixed 32 registers × 32 bits; 5-bit addresses.
- clk_i  input  1  clock; all register writes occur on its rising edge.
- rst_i  input  1  reset; asynchronous, active-high.
- RegWrite_i  input  1  writeback enable from MEM/WB.
- MemtoReg_i  input  1  1 = write dataMem_data_i, 0 = write ALU_result_i.
- dataMem_data_i  input  32  load data from MEM/WB.
- ALU_result_i  input  32  ALU result from MEM/WB.
- RDaddr_i  input  5  destination register from MEM/WB.
- RSaddr_i  input  5  read port A address (ID stage).
- RTaddr_i  input  5  read port B address (ID stage).
- RSdata_o  output  32  read port A data.
- RTdata_o  output  32  read port B data.
- WBdata_o  output  32  selected writeback value (for forwarding).
- WBaddr_o  output  5  RDaddr_i when the write is effective, else 0.
- WBvalid_o  output  1  1 when the write is effective (RegWrite_i=1 and RDaddr_i≠0).

## Operation
- Writeback select: WBdata_o = MemtoReg_i ? dataMem_data_i : ALU_result_i. Purely combinational, no width change.
- Effective write: we = RegWrite_i && (RDaddr_i != 0). WBvalid_o = we. WBaddr_o = we ? RDaddr_i : 0.
- Commit: at the rising clk_i edge, if we=1 and rst_i=0, reg[RDaddr_i] <= WBdata_o. Otherwise the array holds its value.
- Register 0 is hardwired to zero. It is never written, and reads of address 0 always return 0, including under bypass.
- Read ports are combinational. For each port P with address A:
  - A = 0 → 0.
  - else if we=1 and A = RDaddr_i → WBdata_o (write-through bypass, so an instruction in ID sees the value being written back in the same cycle).
  - else → reg[A].
- Both ports may read the same address, or the write address, simultaneously. Each port resolves independently with the same rule.
- MemtoReg_i is ignored for commit purposes when RegWrite_i=0. WBdata_o still reflects the mux.

## Timing
- Reset: while rst_i=1, all 32 registers clear to 0 immediately, asynchronously to clk_i, and no write occurs on any edge during reset.
  - After reset, RSdata_o and RTdata_o return 0 for any address unless a bypass hit applies (combinational inputs still drive bypass).
  - WBdata_o, WBaddr_o and WBvalid_o are combinational and have no reset value of their own.
- Reset asserted mid-operation discards the array contents. A write presented in the same cycle rst_i falls is committed on the next rising edge with rst_i=0.
- Write latency: one edge. The value is visible through the array from the cycle after the edge, and through bypass in the same cycle.
- Read latency: zero cycles (combinational from the address and MEM/WB inputs).
- No handshake and no stall input. MEM/WB holds its outputs across stalls, and a repeated write of the same value is harmless.

## Test plan
- Reset: pulse rst_i asynchronously (not aligned to clk_i) after writing reg5=0xDEADBEEF. Required: RSaddr_i=5 → RSdata_o=0 immediately, with no clock edge needed.
- Basic write/read: RegWrite_i=1, MemtoReg_i=0, ALU_result_i=0x12345678, RDaddr_i=7, one edge, then RegWrite_i=0. Required: RSaddr_i=7 → 0x12345678. With MemtoReg_i=1, dataMem_data_i=0xCAFEF00D, RDaddr_i=8: RTaddr_i=8 → 0xCAFEF00D.
- Bypass: present a write of 0xA5A5A5A5 to r9 and set RSaddr_i=RTaddr_i=9 in the same cycle, before the edge. Required: both ports = 0xA5A5A5A5, WBvalid_o=1, WBaddr_o=9.
- r0 protection: RegWrite_i=1, RDaddr_i=0, ALU_result_i=0xFFFFFFFF. Required: WBvalid_o=0, WBaddr_o=0, RSaddr_i=0 → 0 both before and after the edge.
- Write disabled: RegWrite_i=0, RDaddr_i=7, ALU_result_i=0x1. Required: no bypass, and r7 keeps 0x12345678 after the edge.
- Back-to-back: writes to r3 of 1, 2, 3 on consecutive edges, with RSaddr_i=3. Required: RSdata_o tracks 1, 2, 3 in the same cycle each write is presented, and reads 3 once writes stop.
